// File: rtl/merger_pkg.sv
// Shared definitions for the SpGEMM coordinate merger: coordinate width,
// drained-lane sentinel and comparator-tree sizing helper.
package merger_pkg;

    localparam int COORD_BITS = 8;

    // Drained lanes present this value so they lose to any live coordinate.
    localparam logic [COORD_BITS-1:0] COORD_SENTINEL = '1;

    // Number of operands alive at tree level lvl when the tree has n leaves.
    function automatic int level_width(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/merger_cmp_node.sv
// Two-input unsigned minimum with lane index; the left (lower-index) operand
// wins ties so the fetch request stays deterministic.
module merger_cmp_node import merger_pkg::*; #(
    parameter int W  = COORD_BITS,
    parameter int IW = 1
) (
    input  logic [W-1:0]  a_val_i,
    input  logic [IW-1:0] a_idx_i,
    input  logic [W-1:0]  b_val_i,
    input  logic [IW-1:0] b_idx_i,
    output logic [W-1:0]  min_val_o,
    output logic [IW-1:0] min_idx_o
);

    logic take_b;

    assign take_b    = (b_val_i < a_val_i);
    assign min_val_o = take_b ? b_val_i : a_val_i;
    assign min_idx_o = take_b ? b_idx_i : a_idx_i;

endmodule

// File: rtl/merger.sv
// Radix-N coordinate merger: registers the minimum lane coordinate every cycle
// and, when selected downstream, a one-hot fetch request to the winning lane.
module merger import merger_pkg::*; #(
    parameter int MERGER_RADIX      = 2,
    parameter int MERGER_COORD_BITS = COORD_BITS
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [MERGER_RADIX*MERGER_COORD_BITS-1:0] coord_in,
    output logic [MERGER_COORD_BITS-1:0]           coord,
    input  logic                                   selected,
    output logic [MERGER_RADIX-1:0]                fetch_next
);

    localparam int W      = MERGER_COORD_BITS;
    localparam int IW     = $clog2(MERGER_RADIX);
    localparam int LEVELS = $clog2(MERGER_RADIX);

    logic [W-1:0]  lvl_val [LEVELS+1][MERGER_RADIX];
    logic [IW-1:0] lvl_idx [LEVELS+1][MERGER_RADIX];

    logic [W-1:0]            coord_d,  coord_q;
    logic [MERGER_RADIX-1:0] fetch_d,  fetch_q;

    genvar l, j;

    for (j = 0; j < MERGER_RADIX; j++) begin : g_leaf
        assign lvl_val[0][j] = coord_in[j*W +: W];
        assign lvl_idx[0][j] = IW'(j);
    end

    // Pairs (2j, 2j+1) reduce into slot j; an unpaired last operand rides up.
    for (l = 0; l < LEVELS; l++) begin : g_level
        for (j = 0; j < MERGER_RADIX; j++) begin : g_slot
            if (j < level_width(MERGER_RADIX, l + 1)) begin : g_used
                if (2*j + 1 < level_width(MERGER_RADIX, l)) begin : g_cmp
                    merger_cmp_node #(
                        .W  (W),
                        .IW (IW)
                    ) u_node (
                        .a_val_i   (lvl_val[l][2*j]),
                        .a_idx_i   (lvl_idx[l][2*j]),
                        .b_val_i   (lvl_val[l][2*j+1]),
                        .b_idx_i   (lvl_idx[l][2*j+1]),
                        .min_val_o (lvl_val[l+1][j]),
                        .min_idx_o (lvl_idx[l+1][j])
                    );
                end else begin : g_pass
                    assign lvl_val[l+1][j] = lvl_val[l][2*j];
                    assign lvl_idx[l+1][j] = lvl_idx[l][2*j];
                end
            end else begin : g_unused
                assign lvl_val[l+1][j] = '0;
                assign lvl_idx[l+1][j] = '0;
            end
        end
    end

    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        fetch_d = '0;
        coord_d = lvl_val[LEVELS][0];
        if (selected) begin
            fetch_d[lvl_idx[LEVELS][0]] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            coord_q <= '0;
            fetch_q <= '0;
        end else begin
            coord_q <= coord_d;
            fetch_q <= fetch_d;
        end
    end

    assign coord      = coord_q;
    assign fetch_next = fetch_q;

endmodule

// File: tb/tb_merger.sv
// Directed self-checking bench for merger at radix 2 and radix 5.
module tb_merger;
    import merger_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] c2_in;
    logic        sel2;
    logic [7:0]  coord2;
    logic [1:0]  fetch2;
    logic [39:0] c5_in;
    logic        sel5;
    logic [7:0]  coord5;
    logic [4:0]  fetch5;

    int checks = 0;
    int errors = 0;

    merger #(.MERGER_RADIX(2), .MERGER_COORD_BITS(8)) u_dut2 (
        .clock      (clock),
        .reset      (reset),
        .coord_in   (c2_in),
        .coord      (coord2),
        .selected   (sel2),
        .fetch_next (fetch2)
    );

    merger #(.MERGER_RADIX(5), .MERGER_COORD_BITS(8)) u_dut5 (
        .clock      (clock),
        .reset      (reset),
        .coord_in   (c5_in),
        .coord      (coord5),
        .selected   (sel5),
        .fetch_next (fetch5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        c2_in = '0;
        sel2  = 1'b0;
        c5_in = '0;
        sel5  = 1'b0;
        #1;
        check("rst_coord2", 32'(coord2), 32'd0);
        check("rst_fetch2", 32'(fetch2), 32'd0);
        check("rst_coord5", 32'(coord5), 32'd0);
        check("rst_fetch5", 32'(fetch5), 32'd0);

        // Outputs must hold reset values across edges while reset is high.
        c2_in = {8'd2, 8'd3};
        sel2  = 1'b1;
        step();
        step();
        check("rst_hold_coord2", 32'(coord2), 32'd0);
        check("rst_hold_fetch2", 32'(fetch2), 32'd0);
        reset = 1'b0;

        // lane0=3, lane1=2, selected
        c5_in = {8'd200, 8'd4, 8'd7, 8'd4, 8'd9};
        sel5  = 1'b1;
        step();
        check("r2_min1_coord", 32'(coord2), 32'd2);
        check("r2_min1_fetch", 32'(fetch2), 32'b10);
        check("r5_coord",      32'(coord5), 32'd4);
        check("r5_fetch",      32'(fetch5), 32'b00010);
        step();
        check("r2_min1_hold_fetch", 32'(fetch2), 32'b10);

        sel2 = 1'b0;
        step();
        check("r2_nosel_coord", 32'(coord2), 32'd2);
        check("r2_nosel_fetch", 32'(fetch2), 32'b00);

        c2_in = {8'd3, 8'd2};
        sel2  = 1'b1;
        step();
        check("r2_min0_coord", 32'(coord2), 32'd2);
        check("r2_min0_fetch", 32'(fetch2), 32'b01);
        sel2 = 1'b0;
        step();
        check("r2_min0_nosel_coord", 32'(coord2), 32'd2);
        check("r2_min0_nosel_fetch", 32'(fetch2), 32'b00);

        c2_in = {8'd5, 8'd5};
        sel2  = 1'b1;
        step();
        check("r2_tie_coord", 32'(coord2), 32'd5);
        check("r2_tie_fetch", 32'(fetch2), 32'b01);

        c2_in = {COORD_SENTINEL, COORD_SENTINEL};
        c5_in = {5{COORD_SENTINEL}};
        step();
        check("r2_drain_coord", 32'(coord2), 32'hFF);
        check("r2_drain_fetch", 32'(fetch2), 32'b01);
        check("r5_drain_coord", 32'(coord5), 32'hFF);
        check("r5_drain_fetch", 32'(fetch5), 32'b00001);

        // Radix 5: minimum in the odd leftover lane (passes through levels).
        c5_in = {8'd10, 8'd200, 8'd30, 8'd30, 8'd50};
        sel5  = 1'b0;
        step();
        check("r5_last_nosel_coord", 32'(coord5), 32'd10);
        check("r5_last_nosel_fetch", 32'(fetch5), 32'b00000);
        sel5 = 1'b1;
        step();
        check("r5_last_fetch", 32'(fetch5), 32'b10000);
        c5_in = {8'd10, 8'd200, 8'd3, 8'd30, 8'd50};
        step();
        check("r5_mid_coord", 32'(coord5), 32'd3);
        check("r5_mid_fetch", 32'(fetch5), 32'b00100);

        // Mid-cycle reset while a fetch is pending.
        c2_in = {8'd2, 8'd3};
        sel2  = 1'b1;
        step();
        check("pre_rst_fetch2", 32'(fetch2), 32'b10);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_coord2", 32'(coord2), 32'd0);
        check("async_rst_fetch2", 32'(fetch2), 32'd0);
        check("async_rst_fetch5", 32'(fetch5), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_coord2", 32'(coord2), 32'd2);
        check("post_rst_fetch2", 32'(fetch2), 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
